// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: compares two K-bit words one bit per clock,
// MSB-first with early exit or LSB-first over the full word, behind a start/busy/done handshake.
module serial_magnitude_comparator #(
    parameter int K = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          dir,
    input  logic [K-1:0]                  A,
    input  logic [K-1:0]                  B,
    output logic                          busy,
    output logic                          done,
    output logic                          Z_gt,
    output logic                          Z_eq,
    output logic                          Z_lt,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] bit_idx
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] TOP = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state, state_nx;
    logic [K-1:0]   a_r, b_r;
    logic           dir_r;
    logic [IW-1:0]  idx;
    logic           g, l;
    logic           a_bit, b_bit, diff, g_nx, l_nx, last;

    assign a_bit = a_r[idx];
    assign b_bit = b_r[idx];
    assign diff  = a_bit ^ b_bit;
    // LSB-first flags: a differing bit overrides, so the most significant difference wins
    assign g_nx  = diff ? (a_bit & ~b_bit) : g;
    assign l_nx  = diff ? (~a_bit & b_bit) : l;
    assign last  = dir_r ? (idx == TOP) : (diff || (idx == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            dir_r <= 1'b0;
            idx   <= '0;
            g     <= 1'b0;
            l     <= 1'b0;
            Z_gt  <= 1'b0;
            Z_eq  <= 1'b0;
            Z_lt  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= A;
                    b_r   <= B;
                    dir_r <= dir;
                    idx   <= dir ? '0 : TOP;
                    g     <= 1'b0;
                    l     <= 1'b0;
                    Z_gt  <= 1'b0;
                    Z_eq  <= 1'b0;
                    Z_lt  <= 1'b0;
                end
                SCAN: begin
                    if (!dir_r) begin
                        if (diff) begin
                            Z_gt <= a_bit & ~b_bit;
                            Z_lt <= ~a_bit & b_bit;
                        end else if (idx == '0) begin
                            Z_eq <= 1'b1;
                        end
                    end else begin
                        g <= g_nx;
                        l <= l_nx;
                        if (last) begin
                            Z_gt <= g_nx;
                            Z_lt <= l_nx;
                            Z_eq <= ~(g_nx | l_nx);
                        end
                    end
                    // idx parks at 0 when leaving SCAN so bit_idx reads 0 outside SCAN
                    if (last)       idx <= '0;
                    else if (dir_r) idx <= idx + 1'b1;
                    else            idx <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign bit_idx = idx;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: a K=5 instance for the main
// scenarios and a K=1 instance for the single-bit corner.
module tb_serial_magnitude_comparator;
    logic       clk = 1'b0;
    logic       reset;
    logic       start, dir;
    logic [4:0] A, B;
    logic       busy, done, Z_gt, Z_eq, Z_lt;
    logic [2:0] bit_idx;

    logic       start1, dir1;
    logic [0:0] A1, B1;
    logic       busy1, done1, gt1, eq1, lt1;
    logic [0:0] idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.K(5)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .A(A), .B(B),
        .busy(busy), .done(done), .Z_gt(Z_gt), .Z_eq(Z_eq), .Z_lt(Z_lt), .bit_idx(bit_idx)
    );

    serial_magnitude_comparator #(.K(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .dir(dir1), .A(A1), .B(B1),
        .busy(busy1), .done(done1), .Z_gt(gt1), .Z_eq(eq1), .Z_lt(lt1), .bit_idx(idx1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue a start on the K=5 instance; returns just after the start edge E0
    task automatic launch(input logic d, input logic [4:0] a, input logic [4:0] b);
        dir = d; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // count SCAN edges until done appears; 20 means it never came
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dir = 1'b0; A = '0; B = '0;
        start1 = 1'b0; dir1 = 1'b0; A1 = '0; B1 = '0;
        tick(); tick();
        checks++;
        if ({busy, done, Z_gt, Z_eq, Z_lt, bit_idx} !== 8'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 00000000", {busy, done, Z_gt, Z_eq, Z_lt, bit_idx});
        end
        checks++;
        if ({busy1, done1, gt1, eq1, lt1, idx1} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs_k1 got %b want 000000", {busy1, done1, gt1, eq1, lt1, idx1});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        int n;
        launch(1'b0, 5'b10110, 5'b10011);
        checks++;
        if (bit_idx !== 3'd4 || busy !== 1'b1) begin
            errors++; $display("FAIL msb_first_start got idx=%0d busy=%b want idx=4 busy=1", bit_idx, busy);
        end
        wait_done(n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL msb_first_latency got %0d want 3", n);
        end
        checks++;
        if ({Z_gt, Z_eq, Z_lt, busy, bit_idx} !== 7'b1001000) begin
            errors++; $display("FAIL msb_first_result got %b want 1001000", {Z_gt, Z_eq, Z_lt, busy, bit_idx});
        end
        tick();
        checks++;
        if ({busy, done, Z_gt, Z_eq, Z_lt} !== 5'b00100) begin
            errors++; $display("FAIL msb_first_hold got %b want 00100", {busy, done, Z_gt, Z_eq, Z_lt});
        end
    endtask

    task automatic test_lsb_first();
        int n;
        launch(1'b1, 5'b10110, 5'b10011);
        checks++;
        if (bit_idx !== 3'd0 || {Z_gt, Z_eq, Z_lt} !== 3'b000) begin
            errors++; $display("FAIL lsb_first_start got idx=%0d flags=%b want idx=0 flags=000", bit_idx, {Z_gt, Z_eq, Z_lt});
        end
        tick(); tick();
        checks++;
        if (bit_idx !== 3'd2) begin
            errors++; $display("FAIL lsb_first_idx got %0d want 2", bit_idx);
        end
        wait_done(n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL lsb_first_latency got %0d want 3 more edges", n);
        end
        checks++;
        if ({Z_gt, Z_eq, Z_lt} !== 3'b100) begin
            errors++; $display("FAIL lsb_first_result got %b want 100", {Z_gt, Z_eq, Z_lt});
        end
        tick();
    endtask

    task automatic test_equal();
        int n;
        for (int d = 0; d < 2; d++) begin
            launch(d[0], 5'b01101, 5'b01101);
            wait_done(n);
            checks++;
            if (n !== 5 || {Z_gt, Z_eq, Z_lt} !== 3'b010) begin
                errors++; $display("FAIL equal_dir%0d got n=%0d flags=%b want n=5 flags=010", d, n, {Z_gt, Z_eq, Z_lt});
            end
            tick();
        end
        launch(1'b0, 5'b00000, 5'b10000);
        wait_done(n);
        checks++;
        if (n !== 1 || {Z_gt, Z_eq, Z_lt} !== 3'b001) begin
            errors++; $display("FAIL msb_diff got n=%0d flags=%b want n=1 flags=001", n, {Z_gt, Z_eq, Z_lt});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_busy, exp_done;
        exp_busy = 11'b01101101111;
        exp_done = 11'b01001001000;
        dir = 1'b0; A = 5'b10110; B = 5'b10011; start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            if (i == 0) A = 5'b00000;
            if (i == 9) start = 1'b0;
            checks++;
            if (busy !== exp_busy[i] || done !== exp_done[i]) begin
                errors++; $display("FAIL b2b_handshake_e%0d got busy=%b done=%b want busy=%b done=%b",
                                   i, busy, done, exp_busy[i], exp_done[i]);
            end
            if (i == 3) begin
                checks++;
                if ({Z_gt, Z_eq, Z_lt} !== 3'b100) begin
                    errors++; $display("FAIL b2b_first_result got %b want 100", {Z_gt, Z_eq, Z_lt});
                end
            end
            if (i == 6 || i == 9) begin
                checks++;
                if ({Z_gt, Z_eq, Z_lt} !== 3'b001) begin
                    errors++; $display("FAIL b2b_later_result_e%0d got %b want 001", i, {Z_gt, Z_eq, Z_lt});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        launch(1'b0, 5'b01101, 5'b01101);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, Z_gt, Z_eq, Z_lt, bit_idx} !== 8'b0) begin
            errors++; $display("FAIL async_reset got %b want 00000000", {busy, done, Z_gt, Z_eq, Z_lt, bit_idx});
        end
        #1 reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL async_reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
        launch(1'b1, 5'b00011, 5'b00001);
        wait_done(n);
        checks++;
        if (n !== 5 || {Z_gt, Z_eq, Z_lt} !== 3'b100) begin
            errors++; $display("FAIL after_reset_op got n=%0d flags=%b want n=5 flags=100", n, {Z_gt, Z_eq, Z_lt});
        end
        tick();
    endtask

    task automatic test_k1();
        for (int d = 0; d < 2; d++) begin
            dir1 = d[0]; A1 = 1'b1; B1 = 1'b0; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || idx1 !== 1'b0) begin
                errors++; $display("FAIL k1_scan_dir%0d got busy=%b done=%b idx=%b want 1 0 0", d, busy1, done1, idx1);
            end
            tick();
            checks++;
            if ({done1, gt1, eq1, lt1, idx1} !== 5'b11000) begin
                errors++; $display("FAIL k1_result_dir%0d got %b want 11000", d, {done1, gt1, eq1, lt1, idx1});
            end
            tick();
            checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b0) begin
                errors++; $display("FAIL k1_idle_dir%0d got busy=%b done=%b want 0 0", d, busy1, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_equal();
        test_back_to_back();
        test_async_reset();
        test_k1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
